// File: rtl/csa_accumulator.sv
// ---------------------------------------------------------------------------
// CsaAccumulator: stream accumulator built on a carry-save adder.
//
// Each accepted operand goes through one full-adder layer into a redundant
// (sum, carry) pair, so the per-operand path is a single full adder deep.
// After the last operand the pair is collapsed by a small R-bit
// ripple adder, one chunk per cycle starting at the lowest chunk. The
// finished result is then held until the consumer takes it.
//
// Parameters
//   W   operand width
//   G   guard bits; accumulator width ACC = W + G
//   R   bits resolved per cycle; NCH = ceil(ACC / R) resolve cycles
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand present
//   in_ready   block accepts an operand (only while accumulating)
//   in_data    unsigned operand
//   in_last    marks the final operand of the stream
//   out_valid  result present (only once fully resolved)
//   out_ready  consumer accepts the result
//   out_sum    stream sum modulo 2^ACC
//   out_ovf    true stream sum was at least 2^ACC
// ---------------------------------------------------------------------------
module csa_accumulator #(
    parameter int W = 20,
    parameter int G = 4,
    parameter int R = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W+G-1:0]   out_sum,
    output logic             out_ovf
);

    localparam int ACC  = W + G;
    localparam int NCH  = (ACC + R - 1) / R;
    localparam int PAD  = NCH * R;
    // Width of the top chunk; its carry-out sits at this bit of the chunk sum.
    localparam int TOPW = ACC - (NCH - 1) * R;
    localparam int CIW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        ACCUM,
        RESOLVE,
        DONE
    } state_e;

    state_e             stateQ, stateD;
    logic [ACC-1:0]     sumQ, sumD;
    logic [ACC-1:0]     carryQ, carryD;
    logic               ovQ, ovD;
    logic               rcarryQ, rcarryD;
    logic [CIW-1:0]     chunkIdxQ, chunkIdxD;
    logic [ACC-1:0]     outSumQ, outSumD;
    logic               outOvfQ, outOvfD;

    logic               inXfer;
    logic               lastChunk;
    logic [ACC-1:0]     operand;
    logic [ACC-1:0]     csaSum;
    logic [ACC-1:0]     csaMaj;
    logic [PAD-1:0]     sPad;
    logic [PAD-1:0]     cPad;
    logic [R-1:0]       sChunk;
    logic [R-1:0]       cChunk;
    logic [R:0]         chunkSum;
    logic               chunkCout;

    // Handshake qualifiers and the carry-save layer. The majority bit of the
    // top position falls off the accumulator; it is worth 2^ACC, so it only
    // feeds the sticky overflow flag.
    always_comb begin
        inXfer    = in_valid && (stateQ == ACCUM);
        lastChunk = (chunkIdxQ == CIW'(NCH - 1));
        operand   = ACC'(in_data);
        csaSum    = sumQ ^ carryQ ^ operand;
        csaMaj    = (sumQ & carryQ) | (sumQ & operand) | (carryQ & operand);
    end

    // Chunk resolver. S and C are zero-padded to a whole number of chunks so
    // the indexed select never runs off the end; with padding, the top
    // chunk's carry-out shows up at bit TOPW rather than bit R.
    always_comb begin
        sPad            = '0;
        cPad            = '0;
        sPad[ACC-1:0]   = sumQ;
        cPad[ACC-1:0]   = carryQ;
        sChunk          = sPad[int'(chunkIdxQ) * R +: R];
        cChunk          = cPad[int'(chunkIdxQ) * R +: R];
        chunkSum        = {1'b0, sChunk} + {1'b0, cChunk} + {{R{1'b0}}, rcarryQ};
        chunkCout       = lastChunk ? chunkSum[TOPW] : chunkSum[R];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= ACCUM;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic: the last operand starts resolution, the last chunk
    // finishes it, and a handoff returns to accumulation.
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            ACCUM:   if (inXfer && in_last) stateD = RESOLVE;
            RESOLVE: if (lastChunk)         stateD = DONE;
            DONE:    if (out_ready)         stateD = ACCUM;
            default:                        stateD = ACCUM;
        endcase
    end

    // Datapath next-state. out_sum is rewritten one chunk at a time during
    // RESOLVE and otherwise keeps its last value, including across a handoff.
    always_comb begin
        sumD      = sumQ;
        carryD    = carryQ;
        ovD       = ovQ;
        rcarryD   = rcarryQ;
        chunkIdxD = chunkIdxQ;
        outSumD   = outSumQ;
        outOvfD   = outOvfQ;
        case (stateQ)
            ACCUM: begin
                if (inXfer) begin
                    sumD   = csaSum;
                    carryD = {csaMaj[ACC-2:0], 1'b0};
                    ovD    = ovQ | csaMaj[ACC-1];
                    if (in_last) begin
                        chunkIdxD = '0;
                        rcarryD   = 1'b0;
                    end
                end
            end
            RESOLVE: begin
                for (int b = 0; b < ACC; b++) begin
                    if ((b / R) == int'(chunkIdxQ)) begin
                        outSumD[b] = chunkSum[b % R];
                    end
                end
                rcarryD = chunkCout;
                if (lastChunk) begin
                    outOvfD = ovQ | chunkCout;
                end else begin
                    chunkIdxD = chunkIdxQ + CIW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    sumD      = '0;
                    carryD    = '0;
                    ovD       = 1'b0;
                    chunkIdxD = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset wins over every other event and drops any
    // stream that was in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            sumQ      <= '0;
            carryQ    <= '0;
            ovQ       <= 1'b0;
            rcarryQ   <= 1'b0;
            chunkIdxQ <= '0;
            outSumQ   <= '0;
            outOvfQ   <= 1'b0;
        end else begin
            sumQ      <= sumD;
            carryQ    <= carryD;
            ovQ       <= ovD;
            rcarryQ   <= rcarryD;
            chunkIdxQ <= chunkIdxD;
            outSumQ   <= outSumD;
            outOvfQ   <= outOvfD;
        end
    end

    // Outputs are pure decodes of registered state, so there is no
    // combinational path from out_ready to in_ready.
    always_comb begin
        in_ready  = (stateQ == ACCUM);
        out_valid = (stateQ == DONE);
        out_sum   = outSumQ;
        out_ovf   = outOvfQ;
    end

endmodule

// File: tb/tb_csa_accumulator.sv
// ---------------------------------------------------------------------------
// Testbench for csa_accumulator. The reference model is the plain integer
// sum of each stream's operands: out_sum is that sum modulo 2^ACC, out_ovf
// says whether it reached 2^ACC, and out_valid must appear exactly NCH
// edges after the last operand is taken.
// ---------------------------------------------------------------------------
module tb_csa_accumulator;

    localparam int W   = 20;
    localparam int G   = 4;
    localparam int R   = 8;
    localparam int ACC = W + G;
    localparam int NCH = (ACC + R - 1) / R;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC-1:0]   out_sum;
    logic             out_ovf;

    int vectors;
    int miscompares;

    logic [W-1:0] streamQ[$];

    csa_accumulator #(.W(W), .G(G), .R(R)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Last-resort guard so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Two-cycle reset, then the idle output values.
    task automatic doReset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("rstInReady",  64'(in_ready),  64'd1);
        checkOutput("rstOutValid", 64'(out_valid), 64'd0);
        checkOutput("rstOutSum",   64'(out_sum),   64'd0);
        checkOutput("rstOutOvf",   64'(out_ovf),   64'd0);
    endtask

    // Sends streamQ as one stream (with random idle gaps), checks latency and
    // result against the integer model, optionally holds the result under
    // backpressure while garbage is offered at the input, then hands off.
    task automatic applyStimulus(input int holdCycles);
        longint         total;
        logic [ACC-1:0] expSum;
        logic           expOvf;
        int             waitN;
        int             lat;
        total = 0;
        for (int i = 0; i < streamQ.size(); i++) begin
            total += longint'(streamQ[i]);
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_data  = W'($urandom);
                in_last  = 1'b1;
                @(negedge clk);
            end
            waitN = 0;
            while (!in_ready && waitN < 50) begin
                @(negedge clk);
                waitN++;
            end
            checkOutput("inReadyBeforeXfer", 64'(in_ready), 64'd1);
            in_valid = 1'b1;
            in_data  = streamQ[i];
            in_last  = (i == streamQ.size() - 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;

        expSum = total[ACC-1:0];
        expOvf = (total >= (longint'(1) <<< ACC));

        checkOutput("outValidAtLast", 64'(out_valid), 64'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency",     64'(lat),       64'(NCH));
        checkOutput("outSum",      64'(out_sum),   64'(expSum));
        checkOutput("outOvf",      64'(out_ovf),   64'(expOvf));
        checkOutput("inReadyDone", 64'(in_ready),  64'd0);

        for (int h = 0; h < holdCycles; h++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            in_last  = 1'($urandom);
            @(negedge clk);
            checkOutput("holdOutSum",   64'(out_sum),   64'(expSum));
            checkOutput("holdOutOvf",   64'(out_ovf),   64'(expOvf));
            checkOutput("holdOutValid", 64'(out_valid), 64'd1);
            checkOutput("holdInReady",  64'(in_ready),  64'd0);
        end

        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        checkOutput("handoffOutValid", 64'(out_valid), 64'd0);
        checkOutput("handoffInReady",  64'(in_ready),  64'd1);
        checkOutput("retainOutSum",    64'(out_sum),   64'(expSum));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        doReset();

        // Basic stream 1+2+3.
        streamQ = {20'd1, 20'd2, 20'd3};
        applyStimulus(0);

        // Carry crossing the chunk 0 / chunk 1 boundary.
        streamQ = {20'h000FF, 20'h00001};
        applyStimulus(0);

        // Sixteen full-scale operands: just below 2^ACC.
        streamQ.delete();
        repeat (16) streamQ.push_back(20'hFFFFF);
        applyStimulus(0);

        // Seventeen full-scale operands: wraps and flags overflow.
        streamQ.delete();
        repeat (17) streamQ.push_back(20'hFFFFF);
        applyStimulus(0);

        // Backpressure for five cycles, then a clean follow-up stream.
        streamQ = {20'h12345, 20'h0ABCD, 20'h00777};
        applyStimulus(5);
        streamQ = {20'h00010, 20'h00020};
        applyStimulus(0);

        // Reset during the second resolve cycle drops the stream.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 20'd1;
        in_last  = 1'b0;
        @(negedge clk);
        in_data  = 20'd2;
        in_last  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midRstInReady",  64'(in_ready),  64'd1);
        checkOutput("midRstOutValid", 64'(out_valid), 64'd0);
        checkOutput("midRstOutSum",   64'(out_sum),   64'd0);
        checkOutput("midRstOutOvf",   64'(out_ovf),   64'd0);
        repeat (4) begin
            @(negedge clk);
            checkOutput("midRstNoResult", 64'(out_valid), 64'd0);
        end
        streamQ = {20'd5};
        applyStimulus(0);

        // Randomised streams, biased toward large operands to reach overflow.
        for (int t = 0; t < 14; t++) begin
            int len;
            len = $urandom_range(1, 20);
            streamQ.delete();
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 1) == 1)
                    streamQ.push_back(20'hFFFFF - W'($urandom_range(0, 15)));
                else
                    streamQ.push_back(W'($urandom));
            end
            applyStimulus($urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/csa_accumulator.md
CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

Interface
REQ-001 The block SHALL have parameter W, default 20, giving the operand width in bits.
REQ-002 The block SHALL have parameter G, default 4, giving the guard bits; the accumulator width is ACC = W+G.
REQ-003 The block SHALL have parameter R, default 8, giving the bits resolved per cycle; NCH = ceil(ACC/R).
REQ-004 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit wide: reset, synchronous and active-high.
REQ-006 Port in_valid SHALL be an input, 1 bit wide: operand present.
REQ-007 Port in_ready SHALL be an output, 1 bit wide: block accepts an operand.
REQ-008 Port in_data SHALL be an input, W bits wide: unsigned operand.
REQ-009 Port in_last SHALL be an input, 1 bit wide: final operand of the current stream.
REQ-010 Port out_valid SHALL be an output, 1 bit wide: result present.
REQ-011 Port out_ready SHALL be an input, 1 bit wide: consumer accepts the result.
REQ-012 Port out_sum SHALL be an output, ACC bits wide: stream sum modulo 2^ACC.
REQ-013 Port out_ovf SHALL be an output, 1 bit wide: true stream sum is at least 2^ACC.

Function
REQ-014 The block SHALL implement states ACCUM, RESOLVE and DONE.
REQ-015 The block SHALL drive in_ready=1 only in ACCUM and out_valid=1 only in DONE, both as registered-state decodes.
REQ-016 An input transfer SHALL occur at an edge where in_valid && in_ready; in_data and in_last SHALL be ignored at all other edges.
REQ-017 On each input transfer the block SHALL zero-extend in_data to ACC bits and apply a full-adder per bit to (S, C, operand).
REQ-018 After that update, S SHALL hold the bitwise sum and C SHALL hold the bitwise carries shifted left by 1, truncated to ACC bits, with C[0]=0.
REQ-019 If the carry out of bit ACC-1 is 1 on any transfer, the block SHALL set sticky flag OV; OV SHALL be cleared only by reset or a result handoff.
REQ-020 An input transfer with in_last=0 SHALL leave the state at ACCUM.
REQ-021 An input transfer with in_last=1 SHALL perform the same update and move the state to RESOLVE, with chunk index 0 and resolve carry 0.
REQ-022 Each RESOLVE cycle SHALL add chunk j of S, chunk j of C and the resolve carry, write the result into chunk j of out_sum, and store the chunk carry-out.
REQ-023 Chunk j SHALL cover bits [jR+R-1 : jR], lowest chunk first; the top chunk SHALL be narrowed to ACC bits.
REQ-024 Exactly NCH RESOLVE cycles SHALL occur; at the edge that processes the last chunk the state SHALL move to DONE.
REQ-025 On entering DONE, out_ovf SHALL equal OV OR the final chunk carry-out.
REQ-026 Latency: if in_last is accepted at edge k, out_valid SHALL be 1 after edge k+NCH (3 cycles with default parameters).
REQ-027 In DONE, out_sum and out_ovf SHALL hold stable until a handoff edge (out_valid && out_ready).
REQ-028 At a handoff edge the block SHALL clear S, C, OV and the chunk index and move to ACCUM; in_ready SHALL rise after that edge, with no same-cycle bypass.
REQ-029 A one-operand stream (in_last=1 on the first transfer) SHALL yield that operand as out_sum.
REQ-030 out_sum SHALL retain its last value while in ACCUM, until it is overwritten chunk by chunk during RESOLVE.
REQ-031 Operands and sums SHALL be unsigned; no signed mode SHALL be provided.

Reset
REQ-032 While rst=1 at an edge, the block SHALL clear S, C, OV, the resolve carry, the chunk index, out_sum and out_ovf, and set state ACCUM; this SHALL take priority over all other events.
REQ-033 After reset the outputs SHALL be in_ready=1, out_valid=0, out_sum=0 and out_ovf=0.
REQ-034 A reset asserted in RESOLVE or DONE SHALL abandon the current stream with no partial result presented.

Verification
REQ-035 The bench SHALL cover reset behaviour: assert rst for 2 cycles -> in_ready=1, out_valid=0, out_sum=0, out_ovf=0.
REQ-036 The bench SHALL cover a basic stream: operands 1, 2, 3 with in_last on the 3rd -> out_sum=6, out_ovf=0, out_valid high exactly 3 edges after the last transfer.
REQ-037 The bench SHALL cover carry across a chunk boundary: stream 0x000FF, 0x00001 (last) -> out_sum=0x000100; also stream 16 x 0xFFFFF -> out_sum=0xFFFFF0, out_ovf=0.
REQ-038 The bench SHALL cover overflow: stream 17 x 0xFFFFF -> out_sum=0x0FFFEF, out_ovf=1.
REQ-039 The bench SHALL cover backpressure: out_ready=0 for 5 cycles with in_valid=1 and varying in_data -> out_sum and out_ovf stable, in_ready=0, no operand absorbed; the next stream after handoff sums correctly.
REQ-040 The bench SHALL cover reset mid-operation: rst during the 2nd RESOLVE cycle, then stream 5 (last) -> out_sum=5, out_ovf=0.
